// File: rtl/mem_copy_engine_if.sv
// Signal bundle for mem_copy_engine: copy control/status, byte-wide ROM port and word-wide RAM port.
// The master modport is the engine side; the slave modport is the system/memory side.
interface mem_copy_engine_if #(
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned SRC_AW         = 13,
  parameter int unsigned DST_AW         = 15,
  parameter int unsigned LEN_W          = 16
);
  logic                             START;
  logic                             ABORT;
  logic [SRC_AW-1:0]                SRC_BASE;
  logic [DST_AW-1:0]                DST_BASE;
  logic [LEN_W-1:0]                 LEN;
  logic                             ROM_EN;
  logic [SRC_AW-1:0]                ROM_ADDR;
  logic [BYTE_W-1:0]                ROM_DATA;
  logic                             RAM_WE;
  logic [DST_AW-1:0]                RAM_ADDR;
  logic [BYTE_W*BYTES_PER_WORD-1:0] RAM_WDATA;
  logic                             BUSY;
  logic                             DONE;
  logic [LEN_W-1:0]                 WORDS_DONE;

  modport master (
    input  START, ABORT, SRC_BASE, DST_BASE, LEN, ROM_DATA,
    output ROM_EN, ROM_ADDR, RAM_WE, RAM_ADDR, RAM_WDATA, BUSY, DONE, WORDS_DONE
  );

  modport slave (
    output START, ABORT, SRC_BASE, DST_BASE, LEN, ROM_DATA,
    input  ROM_EN, ROM_ADDR, RAM_WE, RAM_ADDR, RAM_WDATA, BUSY, DONE, WORDS_DONE
  );
endinterface

// File: rtl/mem_copy_engine.sv
// ROM-to-RAM copy engine: fetches BYTES_PER_WORD bytes from a synchronous byte ROM,
// assembles them into one RAM word and writes it, LEN times, with abort and sticky DONE.
module mem_copy_engine #(
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned SRC_AW         = 13,
  parameter int unsigned DST_AW         = 15,
  parameter int unsigned LEN_W          = 16,
  parameter bit          BIG_ENDIAN     = 1'b1
) (
  input logic               CLK,
  input logic               RST_N,
  mem_copy_engine_if.master bus
);
  localparam int unsigned WordW = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned IdxW  = $clog2(BYTES_PER_WORD + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            state_q, state_d;
  logic [SRC_AW-1:0] src_ptr_q, src_ptr_d, rom_addr_q, rom_addr_d;
  logic [DST_AW-1:0] dst_ptr_q, dst_ptr_d, ram_addr_q, ram_addr_d;
  logic [LEN_W-1:0]  len_q, len_d, words_q, words_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WordW-1:0]  word_q, word_d, wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              fetch, store, last_word;

  // Lane that receives the i-th byte fetched for a word.
  function automatic int unsigned lane_of(input int unsigned i);
    return BIG_ENDIAN ? (BYTES_PER_WORD - 1 - i) : i;
  endfunction

  assign fetch     = (state_q == StRead) && (idx_q != LastIdx);
  assign store     = (state_q == StWrite);
  assign last_word = (words_q == len_q - LEN_W'(1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.START && (bus.LEN != '0)) state_d = StRead;
      end
      StRead: begin
        if (bus.ABORT)               state_d = StIdle;
        else if (idx_q == LastIdx)   state_d = StWrite;
      end
      StWrite: begin
        state_d = (bus.ABORT || last_word) ? StIdle : StRead;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin : datapath
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    len_d      = len_q;
    words_d    = words_q;
    idx_d      = idx_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          src_ptr_d = bus.SRC_BASE;
          dst_ptr_d = bus.DST_BASE;
          len_d     = bus.LEN;
          words_d   = '0;
          idx_d     = '0;
          done_d    = (bus.LEN == '0);
        end
      end
      StRead: begin
        if (fetch) begin
          rom_addr_d = src_ptr_q;
          src_ptr_d  = src_ptr_q + SRC_AW'(1);
        end
        // ROM data lags the address by one cycle, so index b carries byte b-1.
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
          if (idx_q == IdxW'(i + 1)) word_d[lane_of(i)*BYTE_W +: BYTE_W] = bus.ROM_DATA;
        end
        idx_d = fetch ? idx_q + IdxW'(1) : '0;
      end
      StWrite: begin
        ram_addr_d = dst_ptr_q;
        wdata_d    = word_q;
        dst_ptr_d  = dst_ptr_q + DST_AW'(1);
        words_d    = words_q + LEN_W'(1);
        idx_d      = '0;
        done_d     = last_word && !bus.ABORT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      len_q      <= '0;
      words_q    <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      len_q      <= len_d;
      words_q    <= words_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  // Addresses and write data show the live value while active, else hold the last one used.
  always_comb begin : outputs
    bus.ROM_EN     = fetch;
    bus.ROM_ADDR   = fetch ? src_ptr_q : rom_addr_q;
    bus.RAM_WE     = store;
    bus.RAM_ADDR   = store ? dst_ptr_q : ram_addr_q;
    bus.RAM_WDATA  = store ? word_q : wdata_q;
    bus.BUSY       = (state_q != StIdle);
    bus.DONE       = done_q;
    bus.WORDS_DONE = words_q;
  end
endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: big- and little-endian instances share stimulus and a byte ROM;
// expected writes come from a byte-level reference model of the copy.
module tb_mem_copy_engine;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BPW    = 4;
  localparam int unsigned SRC_AW = 13;
  localparam int unsigned DST_AW = 15;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned ROM_SZ = 1 << SRC_AW;
  localparam int unsigned RAM_SZ = 1 << DST_AW;

  typedef struct {
    int                cyc;
    logic [DST_AW-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n, start, abort;
  logic [SRC_AW-1:0] src_base;
  logic [DST_AW-1:0] dst_base;
  logic [LEN_W-1:0]  len_in;
  logic [7:0]        rom [ROM_SZ];

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t wq_be[$];
  wr_t wq_le[$];
  logic [SRC_AW-1:0] ra_q[$];
  int  rc_q[$];
  int  done_at;
  bit  busy_h [512];
  bit  done_h [512];
  logic [LEN_W-1:0] wd_h [512];

  always #5 clk = ~clk;

  mem_copy_engine_if #(.BYTE_W(BYTE_W), .BYTES_PER_WORD(BPW), .SRC_AW(SRC_AW), .DST_AW(DST_AW),
                       .LEN_W(LEN_W)) if_be ();
  mem_copy_engine_if #(.BYTE_W(BYTE_W), .BYTES_PER_WORD(BPW), .SRC_AW(SRC_AW), .DST_AW(DST_AW),
                       .LEN_W(LEN_W)) if_le ();

  assign if_be.START = start;    assign if_le.START = start;
  assign if_be.ABORT = abort;    assign if_le.ABORT = abort;
  assign if_be.SRC_BASE = src_base; assign if_le.SRC_BASE = src_base;
  assign if_be.DST_BASE = dst_base; assign if_le.DST_BASE = dst_base;
  assign if_be.LEN = len_in;     assign if_le.LEN = len_in;

  // Synchronous byte ROM: data appears the cycle after the enabled address.
  always @(posedge clk) begin
    if (if_be.ROM_EN === 1'b1) if_be.ROM_DATA <= rom[if_be.ROM_ADDR];
    if (if_le.ROM_EN === 1'b1) if_le.ROM_DATA <= rom[if_le.ROM_ADDR];
  end

  mem_copy_engine #(.BYTE_W(BYTE_W), .BYTES_PER_WORD(BPW), .SRC_AW(SRC_AW), .DST_AW(DST_AW),
                    .LEN_W(LEN_W), .BIG_ENDIAN(1'b1)) u_be (.CLK(clk), .RST_N(rst_n), .bus(if_be));
  mem_copy_engine #(.BYTE_W(BYTE_W), .BYTES_PER_WORD(BPW), .SRC_AW(SRC_AW), .DST_AW(DST_AW),
                    .LEN_W(LEN_W), .BIG_ENDIAN(1'b0)) u_le (.CLK(clk), .RST_N(rst_n), .bus(if_le));

  // Word k of a copy: the BPW consecutive ROM bytes starting at src + k*BPW.
  function automatic logic [31:0] model_word(input int src, input int k, input bit big);
    logic [31:0] w = '0;
    for (int j = 0; j < int'(BPW); j++) begin
      logic [7:0] b;
      b = rom[(src + k * int'(BPW) + j) % int'(ROM_SZ)];
      if (big) w = {w[23:0], b};
      else     w[8*j +: 8] = b;
    end
    return w;
  endfunction

  // Scores the recorded writes of one instance against the model; returns the number of misses.
  function automatic int write_errs(input bit le, input int src, input int dst, input int len,
                                    output string why);
    int  errs = 0;
    int  n;
    wr_t w;
    n   = le ? wq_le.size() : wq_be.size();
    why = "none";
    if (n != len) begin
      errs++;
      why = $sformatf("write count got %0d want %0d", n, len);
    end
    for (int k = 0; k < n && k < len; k++) begin
      logic [31:0]       exp_d;
      logic [DST_AW-1:0] exp_a;
      int                exp_c;
      w     = le ? wq_le[k] : wq_be[k];
      exp_d = model_word(src, k, !le);
      exp_a = DST_AW'((dst + k) % int'(RAM_SZ));
      exp_c = (k + 1) * int'(BPW + 2);
      if (w.cyc != exp_c || w.addr !== exp_a || w.data !== exp_d) begin
        if (errs == 0)
          why = $sformatf("word %0d got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                          k, w.cyc, w.addr, w.data, exp_c, exp_a, exp_d);
        errs++;
      end
    end
    return errs;
  endfunction

  // Drives START at cycle 0 and records outputs at cycles 1..ncyc (sampled 1 unit after the edge).
  task automatic do_copy(input int src, input int dst, input int len, input bit abort0,
                         input int abort_at, input int sstart_at, input int rst_at, input int ncyc);
    wq_be.delete(); wq_le.delete(); ra_q.delete(); rc_q.delete();
    done_at = -1;
    foreach (busy_h[i]) begin
      busy_h[i] = 1'b0; done_h[i] = 1'b0; wd_h[i] = '0;
    end
    src_base = SRC_AW'(src);
    dst_base = DST_AW'(dst);
    len_in   = LEN_W'(len);
    start    = 1'b1;
    abort    = abort0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; rst_n = 1'b1;
      if (c == abort_at) abort = 1'b1;
      if (c == sstart_at) begin
        start    = 1'b1;
        src_base = SRC_AW'($urandom);
        dst_base = DST_AW'($urandom);
        len_in   = LEN_W'($urandom_range(1, 9));
      end
      if (c == rst_at) rst_n = 1'b0;
      if (if_be.RAM_WE === 1'b1) wq_be.push_back('{c, if_be.RAM_ADDR, if_be.RAM_WDATA});
      if (if_le.RAM_WE === 1'b1) wq_le.push_back('{c, if_le.RAM_ADDR, if_le.RAM_WDATA});
      if (if_be.ROM_EN === 1'b1) begin
        ra_q.push_back(if_be.ROM_ADDR);
        rc_q.push_back(c);
      end
      busy_h[c] = if_be.BUSY;
      done_h[c] = if_be.DONE;
      wd_h[c]   = if_be.WORDS_DONE;
      if (if_be.DONE === 1'b1 && done_at < 0) done_at = c;
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    src_base = '1; dst_base = '1; len_in = LEN_W'(5);
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (if_be.ROM_EN !== 1'b0 || if_be.RAM_WE !== 1'b0 || if_be.BUSY !== 1'b0 ||
          if_be.DONE !== 1'b0 || if_be.ROM_ADDR !== '0 || if_be.RAM_ADDR !== '0 ||
          if_be.RAM_WDATA !== '0 || if_be.WORDS_DONE !== '0) begin
        n_fail++;
        $display("FAIL reset_be: got en=%b we=%b busy=%b done=%b ra=%h wa=%h wd=%h cnt=%h want all 0",
                 if_be.ROM_EN, if_be.RAM_WE, if_be.BUSY, if_be.DONE, if_be.ROM_ADDR,
                 if_be.RAM_ADDR, if_be.RAM_WDATA, if_be.WORDS_DONE);
      end
      n_checks++;
      if (if_le.ROM_EN !== 1'b0 || if_le.RAM_WE !== 1'b0 || if_le.BUSY !== 1'b0 ||
          if_le.DONE !== 1'b0 || if_le.ROM_ADDR !== '0 || if_le.RAM_ADDR !== '0 ||
          if_le.RAM_WDATA !== '0 || if_le.WORDS_DONE !== '0) begin
        n_fail++;
        $display("FAIL reset_le: got en=%b we=%b busy=%b done=%b want all 0",
                 if_le.ROM_EN, if_le.RAM_WE, if_le.BUSY, if_le.DONE);
      end
    end
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (if_be.BUSY !== 1'b0 || if_be.ROM_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b rom_en=%b want 0 0", if_be.BUSY, if_be.ROM_EN);
    end
  endtask

  task automatic test_basic();
    string why;
    int    e;
    for (int i = 0; i < 8; i++) rom[i] = 8'(i);
    do_copy(0, 'h10, 2, 1'b0, -1, -1, -1, 14);
    e = write_errs(1'b0, 0, 'h10, 2, why);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL basic_be_writes: %0d bad, %s", e, why); end
    e = write_errs(1'b1, 0, 'h10, 2, why);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL basic_le_writes: %0d bad, %s", e, why); end
    n_checks++;
    if (wq_be.size() != 2 || wq_be[0].data !== 32'h00010203 || wq_be[1].data !== 32'h04050607) begin
      n_fail++;
      $display("FAIL basic_be_literal: got %0d writes first=%h want 00010203 04050607",
               wq_be.size(), (wq_be.size() > 0) ? wq_be[0].data : 32'hx);
    end
    n_checks++;
    if (wq_le.size() != 2 || wq_le[0].data !== 32'h03020100 || wq_le[1].data !== 32'h07060504) begin
      n_fail++;
      $display("FAIL basic_le_literal: got %0d writes first=%h want 03020100 07060504",
               wq_le.size(), (wq_le.size() > 0) ? wq_le[0].data : 32'hx);
    end
    n_checks++;
    if (done_at != 13 || wd_h[13] !== LEN_W'(2)) begin
      n_fail++;
      $display("FAIL basic_done: got done_at=%0d words=%0d want 13 2", done_at, wd_h[13]);
    end
    n_checks++;
    if (busy_h[1] !== 1'b1 || busy_h[12] !== 1'b1 || busy_h[13] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got c1=%b c12=%b c13=%b want 1 1 0",
               busy_h[1], busy_h[12], busy_h[13]);
    end
    e = 0;
    for (int i = 0; i < ra_q.size() && i < 8; i++)
      if (ra_q[i] !== SRC_AW'(i) || rc_q[i] != (i / 4) * 6 + 1 + (i % 4)) e++;
    n_checks++;
    if (ra_q.size() != 8 || e != 0) begin
      n_fail++;
      $display("FAIL basic_rom_reads: got %0d reads %0d misplaced want 8 reads 0", ra_q.size(), e);
    end
  endtask

  task automatic test_wrap();
    string why;
    int    e;
    do_copy('h1FFE, 'h7FFF, 2, 1'b0, -1, -1, -1, 14);
    e = write_errs(1'b0, 'h1FFE, 'h7FFF, 2, why);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL wrap_be_writes: %0d bad, %s", e, why); end
    e = write_errs(1'b1, 'h1FFE, 'h7FFF, 2, why);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL wrap_le_writes: %0d bad, %s", e, why); end
    n_checks++;
    if (wq_be.size() != 2 || wq_be[0].addr !== 15'h7FFF || wq_be[1].addr !== 15'h0000) begin
      n_fail++;
      $display("FAIL wrap_ram_addr: got %0d writes want addresses 7fff 0000", wq_be.size());
    end
    e = 0;
    for (int i = 0; i < ra_q.size(); i++)
      if (ra_q[i] !== SRC_AW'((32'h1FFE + i) % ROM_SZ)) e++;
    n_checks++;
    if (ra_q.size() != 8 || e != 0 || ra_q[2] !== 13'h0000) begin
      n_fail++;
      $display("FAIL wrap_rom_addr: got %0d reads %0d wrong want 8 reads 1ffe,1fff,0000,...",
               ra_q.size(), e);
    end
  endtask

  task automatic test_zero_len();
    do_copy(5, 5, 0, 1'b0, -1, -1, -1, 3);
    n_checks++;
    if (done_at != 1 || ra_q.size() != 0 || wq_be.size() + wq_le.size() != 0 ||
        busy_h[1] !== 1'b0 || busy_h[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: got done_at=%0d reads=%0d writes=%0d busy=%b want 1 0 0 0",
               done_at, ra_q.size(), wq_be.size() + wq_le.size(), busy_h[1]);
    end
  endtask

  task automatic test_abort();
    string why;
    int    e;
    int    src, dst;
    src = int'($urandom_range(0, ROM_SZ - 1));
    dst = int'($urandom_range(0, RAM_SZ - 1));
    do_copy(src, dst, 72, 1'b0, 8, -1, -1, 14);
    e = write_errs(1'b0, src, dst, 1, why);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL abort_writes: %0d bad, %s", e, why); end
    n_checks++;
    if (busy_h[9] !== 1'b0 || done_h[9] !== 1'b0 || wd_h[9] !== LEN_W'(1) || done_at != -1) begin
      n_fail++;
      $display("FAIL abort_status: got busy=%b done=%b words=%0d done_at=%0d want 0 0 1 -1",
               busy_h[9], done_h[9], wd_h[9], done_at);
    end
    n_checks++;
    if (rc_q.size() == 0 || rc_q[rc_q.size()-1] > 8) begin
      n_fail++;
      $display("FAIL abort_rom_quiet: got %0d reads last at %0d want last read <= 8",
               rc_q.size(), (rc_q.size() > 0) ? rc_q[rc_q.size()-1] : -1);
    end
    // Restart with ABORT raised alongside START: the start must still be taken.
    src = int'($urandom_range(0, ROM_SZ - 1));
    dst = int'($urandom_range(0, RAM_SZ - 1));
    do_copy(src, dst, 3, 1'b1, -1, -1, -1, 20);
    e = write_errs(1'b0, src, dst, 3, why) + write_errs(1'b1, src, dst, 3, why);
    n_checks++;
    if (e != 0 || done_at != 19) begin
      n_fail++;
      $display("FAIL abort_restart: got %0d bad done_at=%0d want 0 19 (%s)", e, done_at, why);
    end
  endtask

  task automatic test_start_busy_reset();
    string why;
    int    e;
    int    src, dst;
    src = int'($urandom_range(0, ROM_SZ - 1));
    dst = int'($urandom_range(0, RAM_SZ - 1));
    do_copy(src, dst, 72, 1'b0, -1, 3, 9, 16);
    e = write_errs(1'b0, src, dst, 1, why);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL busy_start_ignored: %0d bad, %s", e, why); end
    n_checks++;
    if (rc_q.size() == 0 || rc_q[rc_q.size()-1] > 9 || busy_h[10] !== 1'b0 || done_at != -1) begin
      n_fail++;
      $display("FAIL reset_mid_copy: got last read=%0d busy10=%b done_at=%0d want <=9 0 -1",
               (rc_q.size() > 0) ? rc_q[rc_q.size()-1] : -1, busy_h[10], done_at);
    end
    n_checks++;
    if (if_be.ROM_EN !== 1'b0 || if_be.RAM_WE !== 1'b0 || if_be.BUSY !== 1'b0 ||
        if_be.DONE !== 1'b0 || if_be.ROM_ADDR !== '0 || if_be.RAM_ADDR !== '0 ||
        if_be.RAM_WDATA !== '0 || if_be.WORDS_DONE !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got ra=%h wa=%h wd=%h cnt=%h busy=%b want all 0",
               if_be.ROM_ADDR, if_be.RAM_ADDR, if_be.RAM_WDATA, if_be.WORDS_DONE, if_be.BUSY);
    end
    src = int'($urandom_range(0, ROM_SZ - 1));
    dst = int'($urandom_range(0, RAM_SZ - 1));
    do_copy(src, dst, 72, 1'b0, -1, -1, -1, 434);
    e = write_errs(1'b0, src, dst, 72, why);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL full72_be_writes: %0d bad, %s", e, why); end
    e = write_errs(1'b1, src, dst, 72, why);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL full72_le_writes: %0d bad, %s", e, why); end
    n_checks++;
    if (done_at != 433 || wd_h[433] !== LEN_W'(72) || busy_h[432] !== 1'b1) begin
      n_fail++;
      $display("FAIL full72_done: got done_at=%0d words=%0d busy432=%b want 433 72 1",
               done_at, wd_h[433], busy_h[432]);
    end
  endtask

  task automatic test_random();
    string why;
    int    e, src, dst, len;
    for (int it = 0; it < 4; it++) begin
      src = int'($urandom_range(0, ROM_SZ - 1));
      dst = int'($urandom_range(0, RAM_SZ - 1));
      len = int'($urandom_range(1, 8));
      do_copy(src, dst, len, 1'($urandom), -1, -1, -1, len * 6 + 2);
      e = write_errs(1'b0, src, dst, len, why) + write_errs(1'b1, src, dst, len, why);
      n_checks++;
      if (e != 0) begin n_fail++; $display("FAIL random%0d_writes: %0d bad, %s", it, e, why); end
      n_checks++;
      if (done_at != len * 6 + 1 || wd_h[len*6+1] !== LEN_W'(len)) begin
        n_fail++;
        $display("FAIL random%0d_done: got done_at=%0d words=%0d want %0d %0d",
                 it, done_at, wd_h[len*6+1], len * 6 + 1, len);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < int'(ROM_SZ); i++) rom[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_abort();
    test_start_busy_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
